// File: rtl/point_catcher.sv
// point_catcher: watches the one-hot moving-point vector and a bouncing
// active-low catch button, scores hits on the target LED, counts misses,
// holds a hit/miss indication and ends the game after MAX_MISS misses.
// fsm_state mirrors the game FSM register for observation.
module point_catcher #(
    parameter int WIDTH       = 18,
    parameter int TARGET      = 17,
    parameter int DEB_CYCLES  = 50000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int MAX_MISS    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             catch_n,
    input  logic [WIDTH-1:0] point_in,
    output logic [4:0]       position,
    output logic             pos_valid,
    output logic             hit_led,
    output logic             miss_led,
    output logic             game_over,
    output logic [7:0]       score_bcd,
    output logic [3:0]       miss_count,
    output logic [1:0]       fsm_state
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]        TGT       = 5'(TARGET);
    localparam logic [3:0]        MISS_END  = 4'(MAX_MISS);

    typedef enum logic [1:0] {PLAY, SHOW_HIT, SHOW_MISS, GAME_OVER} state_t;

    logic [WIDTH-1:0]  p_s1_q, p_s2_q;
    logic              c_s1_q, c_s2_q;
    logic [4:0]        position_q, position_d;
    logic              pos_valid_q, pos_valid_d;
    logic [4:0]        idx_d;

    // Debounced level: 1 = released, 0 = pressed. armed_q stays low after
    // reset until the button has been seen stably released, so a press held
    // through reset cannot produce a pulse.
    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              armed_q, armed_d;
    logic              press_q, press_d;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [7:0]        score_q;
    logic [3:0]        miss_q;
    logic              hit_led_q, miss_led_q, game_over_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)        return s;
        if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // Two-flop synchronizers for the point vector and the button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_s1_q <= '0;
            p_s2_q <= '0;
            c_s1_q <= 1'b1;
            c_s2_q <= 1'b1;
        end else begin
            p_s1_q <= point_in;
            p_s2_q <= p_s1_q;
            c_s1_q <= catch_n;
            c_s2_q <= c_s1_q;
        end
    end

    // Decode the synchronized point; position holds when not one-hot.
    always_comb begin
        idx_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (p_s2_q[i]) idx_d = 5'(i);
        end
        pos_valid_d = $onehot(p_s2_q);
        position_d  = pos_valid_d ? idx_d : position_q;
    end

    // Debounce next-state: level flips after DEB_CYCLES disagreeing cycles.
    always_comb begin
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        armed_d     = armed_q;
        press_d     = 1'b0;
        if (!armed_q) begin
            if (c_s2_q) begin
                if (deb_cnt_q == DEB_LAST) armed_d = 1'b1;
                else                       deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else if (c_s2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = c_s2_q;
                press_d     = ~c_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Decode and debounce registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            position_q  <= '0;
            pos_valid_q <= 1'b0;
            deb_level_q <= 1'b1;
            deb_cnt_q   <= '0;
            armed_q     <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            position_q  <= position_d;
            pos_valid_q <= pos_valid_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            armed_q     <= armed_d;
            press_q     <= press_d;
        end
    end

    // Game FSM with registered LEDs, score and miss counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= PLAY;
            hold_q      <= '0;
            score_q     <= 8'h00;
            miss_q      <= 4'd0;
            hit_led_q   <= 1'b0;
            miss_led_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (press_q) begin
                        if (pos_valid_q && position_q == TGT) begin
                            score_q   <= bcd_inc(score_q);
                            hold_q    <= HOLD_LAST;
                            hit_led_q <= 1'b1;
                            state_q   <= SHOW_HIT;
                        end else begin
                            miss_q     <= miss_q + 4'd1;
                            miss_led_q <= 1'b1;
                            if (miss_q + 4'd1 == MISS_END) begin
                                game_over_q <= 1'b1;
                                state_q     <= GAME_OVER;
                            end else begin
                                hold_q  <= HOLD_LAST;
                                state_q <= SHOW_MISS;
                            end
                        end
                    end
                end
                SHOW_HIT, SHOW_MISS: begin
                    if (hold_q == '0) begin
                        hit_led_q  <= 1'b0;
                        miss_led_q <= 1'b0;
                        state_q    <= PLAY;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (press_q) begin
                        score_q     <= 8'h00;
                        miss_q      <= 4'd0;
                        hit_led_q   <= 1'b0;
                        miss_led_q  <= 1'b0;
                        game_over_q <= 1'b0;
                        state_q     <= PLAY;
                    end
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign position   = position_q;
    assign pos_valid  = pos_valid_q;
    assign hit_led    = hit_led_q;
    assign miss_led   = miss_led_q;
    assign game_over  = game_over_q;
    assign score_bcd  = score_q;
    assign miss_count = miss_q;
    assign fsm_state  = state_q;

endmodule
